// File: rtl/seg7_display.sv
// N-digit 7-segment controller: hex or double-dabble decimal display with
// overflow dashes, leading-zero suppression, per-digit blank and blink.
module seg7_display #(
  parameter int DIGITS     = 6,
  parameter int BLINK_DIV  = 12500000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  mode,
  input  logic                  lzs,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  overflow
);

  localparam int W   = 4 * DIGITS;
  localparam int CW  = $clog2(W);
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Digit symbol codes: 0..15 are glyphs, then blank and dash.
  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_DASH  = 5'd17;
  localparam logic [6:0] SEG_OFF    = (ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     iter_reg, iter_next;
  logic [W-1:0]      shift_reg, shift_next;
  logic [W-1:0]      bcd_reg, bcd_next;
  logic              ovf_reg, ovf_next;
  logic              lzs_reg, lzs_next;
  logic              hex_pend_reg, hex_pend_next;
  logic              commit_dec;
  logic [4:0]        digit_reg [DIGITS];
  logic [4:0]        digit_next [DIGITS];
  logic              overflow_reg, overflow_next;
  logic [BCW-1:0]    blink_cnt_reg, blink_cnt_next;
  logic              phase_reg, phase_next;
  logic [7*DIGITS-1:0] hex_reg, hex_next;
  logic [W-1:0]      bcd_adj;
  logic [DIGITS-1:0] suppress;

  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:    g = 7'b1000000;
      5'd1:    g = 7'b1111001;
      5'd2:    g = 7'b0100100;
      5'd3:    g = 7'b0110000;
      5'd4:    g = 7'b0011001;
      5'd5:    g = 7'b0010010;
      5'd6:    g = 7'b0000010;
      5'd7:    g = 7'b1111000;
      5'd8:    g = 7'b0000000;
      5'd9:    g = 7'b0010000;
      5'd10:   g = 7'b0001000;
      5'd11:   g = 7'b0000011;
      5'd12:   g = 7'b1000110;
      5'd13:   g = 7'b0100001;
      5'd14:   g = 7'b0000110;
      5'd15:   g = 7'b0001110;
      5'd17:   g = 7'b0111111;
      default: g = 7'b1111111;
    endcase
    return (ACTIVE_LOW != 0) ? g : ~g;
  endfunction

  // Add-3 correction applied to every BCD nibble before each shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
  end

  always_comb begin
    state_next    = state_reg;
    iter_next     = iter_reg;
    shift_next    = shift_reg;
    bcd_next      = bcd_reg;
    ovf_next      = ovf_reg;
    lzs_next      = lzs_reg;
    hex_pend_next = 1'b0;
    commit_dec    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          shift_next = value;
          lzs_next   = lzs;
          if (mode) begin
            state_next = ST_CONV;
            bcd_next   = '0;
            ovf_next   = 1'b0;
            iter_next  = '0;
          end else begin
            hex_pend_next = 1'b1;
          end
        end
      end
      ST_CONV: begin
        shift_next = {shift_reg[W-2:0], 1'b0};
        bcd_next   = {bcd_adj[W-2:0], shift_reg[W-1]};
        ovf_next   = ovf_reg | bcd_adj[W-1];
        iter_next  = iter_reg + CW'(1);
        if (iter_reg == CW'(W - 1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        commit_dec = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Leading-zero mask scanned from the top digit down; digit 0 always shows.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    suppress = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      suppress[i] = lzs_reg && !seen && (bcd_reg[4*i +: 4] == 4'd0) && (i != 0);
      seen        = seen | (bcd_reg[4*i +: 4] != 4'd0);
    end
  end

  always_comb begin
    digit_next    = digit_reg;
    overflow_next = overflow_reg;
    if (hex_pend_reg) begin
      overflow_next = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        digit_next[i] = {1'b0, shift_reg[4*i +: 4]};
      end
    end else if (commit_dec) begin
      overflow_next = ovf_reg;
      for (int i = 0; i < DIGITS; i++) begin
        if (ovf_reg) begin
          digit_next[i] = CODE_DASH;
        end else if (suppress[i]) begin
          digit_next[i] = CODE_BLANK;
        end else begin
          digit_next[i] = {1'b0, bcd_reg[4*i +: 4]};
        end
      end
    end
  end

  always_comb begin
    blink_cnt_next = blink_cnt_reg + BCW'(1);
    phase_next     = phase_reg;
    if (blink_cnt_reg == BCW'(BLINK_DIV - 1)) begin
      blink_cnt_next = '0;
      phase_next     = ~phase_reg;
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_out
    assign hex_next[7*gi +: 7] =
      (blank[gi] || (blink[gi] && phase_reg) || (digit_reg[gi] == CODE_BLANK)) ?
      SEG_OFF : glyph(digit_reg[gi]);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= ST_IDLE;
      iter_reg      <= '0;
      shift_reg     <= '0;
      bcd_reg       <= '0;
      ovf_reg       <= 1'b0;
      lzs_reg       <= 1'b0;
      hex_pend_reg  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        digit_reg[i] <= CODE_BLANK;
      end
      overflow_reg  <= 1'b0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      hex_reg       <= {DIGITS{SEG_OFF}};
    end else begin
      state_reg     <= state_next;
      iter_reg      <= iter_next;
      shift_reg     <= shift_next;
      bcd_reg       <= bcd_next;
      ovf_reg       <= ovf_next;
      lzs_reg       <= lzs_next;
      hex_pend_reg  <= hex_pend_next;
      digit_reg     <= digit_next;
      overflow_reg  <= overflow_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
      hex_reg       <= hex_next;
    end
  end

  assign hex      = hex_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign overflow = overflow_reg;

endmodule

// File: doc/seg7_display.md
Name: seg7_display

Overview:
- Parametrised N-digit 7-segment display controller; replaces the fixed "all segments off" tie-offs on the board HEX outputs.
- Hex mode encodes a binary value directly onto the digits.
- Decimal mode runs a sequential double-dabble binary-to-BCD conversion, with overflow detection and leading-zero suppression.
- Adds per-digit blanking and blinking; sits between the CPU/debug logic and the board HEXn pins in the top level.

Parameters:
- DIGITS, 6, number of 7-segment digits driven (1..8).
- BLINK_DIV, 12500000, clock cycles per blink half-period (>=1).
- ACTIVE_LOW, 1, 1: segment on = 0 (DE0-CV); 0: segment on = 1.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- value  in  4*DIGITS  binary value; sampled on accepted load.
- mode  in  1  0 = hex, 1 = decimal; sampled on accepted load.
- lzs  in  1  leading-zero suppression, decimal mode only; sampled on accepted load.
- load  in  1  single-cycle request to display value.
- blank  in  DIGITS  per-digit force-off, live (not sampled).
- blink  in  DIGITS  per-digit blink enable, live.
- hex  out  7*DIGITS  segments; digit i on bits [7i+6:7i]; bit0 = a … bit6 = g.
- busy  out  1  decimal conversion in progress.
- overflow  out  1  last decimal conversion exceeded DIGITS decimal digits.

Behaviour:
- Reset (async, RESET_N=0):
  - hex = all segments off (all 1s if ACTIVE_LOW).
  - Internal digit registers = blank code.
  - busy = 0, overflow = 0, blink counter = 0, blink phase = 0.
  - Reset mid-conversion aborts it; no partial result is ever committed.
- Load acceptance:
  - Accepted only when load=1 and busy=0.
  - load while busy is ignored, not queued.
- Hex mode:
  - Accepted at edge k; digit i = nibble value[4i+3:4i] is committed at edge k+1.
  - busy stays 0 throughout; overflow is cleared at edge k+1.
- Decimal mode FSM: IDLE -> CONV -> DONE -> IDLE.
  - IDLE: accept load; latch value into shift register; clear BCD register (DIGITS nibbles) and sticky ovf; busy=1 from edge k.
  - CONV: exactly W = 4*DIGITS iterations, one per cycle.
    - Each iteration: every BCD nibble >= 5 gets +3, then {bcd, shift} shifts left by 1.
    - If the bit shifted out of the top BCD nibble is 1, set sticky ovf.
  - DONE (one cycle): commit digits and overflow; busy=0. Commit edge = k+W+1 (k+25 for DIGITS=6).
  - Display holds its previous content throughout CONV.
- Decimal commit rules:
  - ovf=1: every digit shows dash (segment g only: 7'b0111111 active-low), overflow=1.
  - Else, with lzs=1: zero digits above the most significant nonzero digit are blanked; digit 0 is never suppressed (value 0 shows "0").
  - Else, with lzs=0: all BCD digits are shown.
- Hex glyphs 0-F (active-low):
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
  - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
  - 8: 0000000, 9: 0010000, A: 0001000, b: 0000011
  - C: 1000110, d: 0100001, E: 0000110, F: 0001110
  - ACTIVE_LOW=0 inverts every glyph and the off code.
- Blink:
  - Free-running counter 0..BLINK_DIV-1; at wrap the phase toggles.
  - Runs independently of loads.
- Output stage:
  - Registered: hex[i] = off if blank[i] | (blink[i] & phase) | digit-blank-code, else glyph.
  - One cycle latency from blank/blink/phase change and from commit to pins.

Test Plan:
- Reset: assert RESET_N=0 mid-operation -> hex = all 1s, busy=0, overflow=0 asynchronously; hold RESET_N=1 with no load -> outputs unchanged.
- Hex mode: value=24'h12AB3F, mode=0 -> after commit + output register, HEX0..5 = F,3,b,A,2,1 glyphs; busy never 1.
- Decimal: value=123456, mode=1, lzs=0, load at edge k -> busy high edges k..k+24, digits 6,5,4,3,2,1 visible after k+26, overflow=0; load pulsed at k+5 ignored.
- Overflow and suppression:
  - value=24'hFFFFFF decimal -> all six digits 0111111, overflow=1.
  - Then value=42 decimal, lzs=1 -> HEX0=2, HEX1=4, HEX2..5 off, overflow=0.
  - value=0, lzs=1 -> HEX0=0 glyph, others off.
- Blink/blank with BLINK_DIV=4: blink=6'b000001, blank=6'b100000 -> HEX0 alternates glyph/off every 4 cycles, HEX5 constantly off, others steady.
- Reset mid-conversion at iteration 10 -> busy=0, display off; a new load afterwards converts correctly.
